// File: rtl/core_sequencer.sv
`timescale 1ns/1ps
// core_sequencer: multi-cycle control FSM for the rv32i core.
// Steps fetch, execute, memory and writeback, with traps and perf counters.
module core_sequencer #(
  parameter int CNT_W     = 64,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_run,
  output logic [2:0]       o_state,
  output logic             o_fetch_valid,
  input  logic             i_fetch_ready,
  input  logic             i_instr_valid,
  input  logic             i_instr_fault,
  output logic             o_instr_ready,
  output logic             o_exec_valid,
  input  logic             i_exec_ready,
  input  logic             i_exec_is_mem,
  input  logic             i_exec_trap,
  output logic             o_mem_valid,
  input  logic             i_mem_ready,
  input  logic             i_rsp_valid,
  input  logic             i_mem_fault,
  output logic             o_rsp_ready,
  output logic             o_wb_en,
  output logic             o_pc_en,
  output logic             o_trap,
  output logic [2:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_cycle,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    EXECUTE    = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WRITEBACK  = 3'd6,
    TRAP       = 3'd7
  } state_t;

  localparam logic [2:0] C_FETCH = 3'd1;
  localparam logic [2:0] C_EXEC  = 3'd2;
  localparam logic [2:0] C_MEM   = 3'd3;
  localparam logic [2:0] C_FTO   = 3'd4;
  localparam logic [2:0] C_MTO   = 3'd5;

  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] W_LAST =
    TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TIMEOUT_W-1:0] W_SAT = '1;

  state_t               state;
  state_t               nxt;
  logic [TIMEOUT_W-1:0] wcnt;
  logic [2:0]           cause;
  logic                 stall;
  logic                 expired;

  assign o_state = state;
  assign expired = TO_EN && (wcnt == W_LAST);

  // A handshake in the expiring cycle still advances the state.
  always_comb begin
    nxt   = state;
    cause = 3'd0;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_run) nxt = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (i_fetch_ready) begin
          nxt = FETCH_WAIT;
        end else begin
          stall = 1'b1;
          if (expired) begin
            nxt   = TRAP;
            cause = C_FTO;
          end
        end
      end
      FETCH_WAIT: begin
        if (i_instr_valid) begin
          if (i_instr_fault) begin
            nxt   = TRAP;
            cause = C_FETCH;
          end else begin
            nxt = EXECUTE;
          end
        end else begin
          stall = 1'b1;
          if (expired) begin
            nxt   = TRAP;
            cause = C_FTO;
          end
        end
      end
      EXECUTE: begin
        if (i_exec_ready) begin
          if (i_exec_trap) begin
            nxt   = TRAP;
            cause = C_EXEC;
          end else if (i_exec_is_mem) begin
            nxt = MEM_REQ;
          end else begin
            nxt = WRITEBACK;
          end
        end
      end
      MEM_REQ: begin
        if (i_mem_ready) begin
          nxt = MEM_WAIT;
        end else begin
          stall = 1'b1;
          if (expired) begin
            nxt   = TRAP;
            cause = C_MTO;
          end
        end
      end
      MEM_WAIT: begin
        if (i_rsp_valid) begin
          if (i_mem_fault) begin
            nxt   = TRAP;
            cause = C_MEM;
          end else begin
            nxt = WRITEBACK;
          end
        end else begin
          stall = 1'b1;
          if (expired) begin
            nxt   = TRAP;
            cause = C_MTO;
          end
        end
      end
      WRITEBACK, TRAP: begin
        nxt = i_run ? FETCH_REQ : IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      wcnt          <= '0;
      o_trap_cause  <= 3'd0;
      o_cycle       <= '0;
      o_instret     <= '0;
      o_fetch_valid <= 1'b0;
      o_instr_ready <= 1'b0;
      o_exec_valid  <= 1'b0;
      o_mem_valid   <= 1'b0;
      o_rsp_ready   <= 1'b0;
      o_wb_en       <= 1'b0;
      o_pc_en       <= 1'b0;
      o_trap        <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        wcnt <= '0;
      end else if (stall && (wcnt != W_SAT)) begin
        wcnt <= wcnt + TIMEOUT_W'(1);
      end
      if (nxt == TRAP) o_trap_cause <= cause;
      if (state != IDLE) o_cycle <= o_cycle + CNT_W'(1);
      if (state == WRITEBACK) o_instret <= o_instret + CNT_W'(1);
      o_fetch_valid <= (nxt == FETCH_REQ);
      o_instr_ready <= (nxt == FETCH_WAIT);
      o_exec_valid  <= (nxt == EXECUTE);
      o_mem_valid   <= (nxt == MEM_REQ);
      o_rsp_ready   <= (nxt == MEM_WAIT);
      o_wb_en       <= (nxt == WRITEBACK);
      o_pc_en       <= (nxt == WRITEBACK) || (nxt == TRAP);
      o_trap        <= (nxt == TRAP);
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
`timescale 1ns/1ps
// tb_core_sequencer: randomized handshake responder with a scoreboard.
// Expected retire/trap outcomes come from per-instruction timing rules.
module tb_core_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        i_run = 1'b0;
  logic [2:0]  o_state;
  logic        o_fetch_valid;
  logic        i_fetch_ready = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic        i_instr_fault = 1'b0;
  logic        o_instr_ready;
  logic        o_exec_valid;
  logic        i_exec_ready = 1'b0;
  logic        i_exec_is_mem = 1'b0;
  logic        i_exec_trap = 1'b0;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic        i_rsp_valid = 1'b0;
  logic        i_mem_fault = 1'b0;
  logic        o_rsp_ready;
  logic        o_wb_en;
  logic        o_pc_en;
  logic        o_trap;
  logic [2:0]  o_trap_cause;
  logic [63:0] o_cycle;
  logic [63:0] o_instret;

  core_sequencer #(
    .CNT_W(64),
    .TIMEOUT_W(8),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_run(i_run),
    .o_state(o_state),
    .o_fetch_valid(o_fetch_valid),
    .i_fetch_ready(i_fetch_ready),
    .i_instr_valid(i_instr_valid),
    .i_instr_fault(i_instr_fault),
    .o_instr_ready(o_instr_ready),
    .o_exec_valid(o_exec_valid),
    .i_exec_ready(i_exec_ready),
    .i_exec_is_mem(i_exec_is_mem),
    .i_exec_trap(i_exec_trap),
    .o_mem_valid(o_mem_valid),
    .i_mem_ready(i_mem_ready),
    .i_rsp_valid(i_rsp_valid),
    .i_mem_fault(i_mem_fault),
    .o_rsp_ready(o_rsp_ready),
    .o_wb_en(o_wb_en),
    .o_pc_en(o_pc_en),
    .o_trap(o_trap),
    .o_trap_cause(o_trap_cause),
    .o_cycle(o_cycle),
    .o_instret(o_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              trap;
    logic [2:0]      cause;
    longint unsigned cyc;
    longint unsigned ret;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n_done = 0;
  longint unsigned mdl_cycle = 0;
  longint unsigned mdl_instret = 0;
  logic [2:0] mdl_cause = 3'd0;
  bit hold_rsp = 1'b0;

  int df, di, de, dm, dr;
  bit ff, et, em, mf;
  logic [6:0] prev = '0;
  logic [6:0] cur;
  int cnt = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 5) == 0) return int'($urandom_range(T - 1, T + 1));
    return int'($urandom_range(0, 2));
  endfunction

  // Outcome of one instruction from its drawn delays and fault flags.
  task automatic new_instr();
    exp_t e;
    int len;
    bit trap;
    logic [2:0] c;
    df = pick_wait();
    di = pick_wait();
    de = int'($urandom_range(0, 3));
    dm = pick_wait();
    dr = pick_wait();
    ff = ($urandom_range(0, 7) == 0);
    et = ($urandom_range(0, 7) == 0);
    em = 1'($urandom);
    mf = ($urandom_range(0, 7) == 0);
    trap = 1'b1;
    c = 3'd0;
    if (df >= T) begin
      len = T; c = 3'd4;
    end else begin
      len = df + 1;
      if (di >= T) begin
        len += T; c = 3'd4;
      end else begin
        len += di + 1;
        if (ff) c = 3'd1;
        else begin
          len += de + 1;
          if (et) c = 3'd2;
          else if (!em) trap = 1'b0;
          else if (dm >= T) begin
            len += T; c = 3'd5;
          end else begin
            len += dm + 1;
            if (dr >= T) begin
              len += T; c = 3'd5;
            end else begin
              len += dr + 1;
              if (mf) c = 3'd3;
              else trap = 1'b0;
            end
          end
        end
      end
    end
    len += 1;
    if (trap) mdl_cause = c;
    e.trap = trap;
    e.cause = mdl_cause;
    e.cyc = mdl_cycle + longint'(len) - 1;
    e.ret = mdl_instret;
    q.push_back(e);
    mdl_cycle += longint'(len);
    if (!trap) mdl_instret++;
  endtask

  // Responder: each handshake rises after its drawn number of cycles.
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      mdl_cycle = 0;
      mdl_instret = 0;
      mdl_cause = 3'd0;
      prev = '0;
      cnt = 0;
    end else begin
      cur = {o_fetch_valid, o_instr_ready, o_exec_valid, o_mem_valid,
             o_rsp_ready, o_wb_en, o_trap};
      if (cur != prev) cnt = 0;
      else cnt++;
      prev = cur;
      if (o_fetch_valid && cnt == 0) new_instr();
      i_fetch_ready = o_fetch_valid ? (cnt == df) : 1'($urandom);
      i_instr_valid = o_instr_ready ? (cnt == di) : 1'($urandom);
      i_instr_fault = (o_instr_ready && cnt == di) ? ff : 1'($urandom);
      i_exec_ready  = o_exec_valid ? (cnt == de) : 1'($urandom);
      i_exec_trap   = (o_exec_valid && cnt == de) ? et : 1'($urandom);
      i_exec_is_mem = (o_exec_valid && cnt == de) ? em : 1'($urandom);
      i_mem_ready   = o_mem_valid ? (cnt == dm) : 1'($urandom);
      i_rsp_valid   = o_rsp_ready ? (!hold_rsp && cnt == dr) : 1'($urandom);
      i_mem_fault   = (o_rsp_ready && cnt == dr) ? mf : 1'($urandom);
    end
  end

  // Monitor: every retire or trap strobe consumes one expected outcome.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && (o_wb_en || o_trap)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: wb %0b trap %0b with empty queue",
                 o_wb_en, o_trap);
      end else begin
        e = q.pop_front();
        check("trap_strobe", 64'(o_trap), 64'(e.trap));
        check("wb_strobe", 64'(o_wb_en), 64'(!e.trap));
        check("strobe_state", 64'(o_state), e.trap ? 64'd7 : 64'd6);
        check("pc_en", 64'(o_pc_en), 64'd1);
        check("trap_cause", 64'(o_trap_cause), 64'(e.cause));
        check("instret", o_instret, e.ret);
        check("cycle", o_cycle, e.cyc);
        n_done++;
      end
    end
  end

  task automatic wait_done(input int target);
    int budget = 20000;
    while (n_done < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: got %0d expected %0d", n_done, target);
    end
  endtask

  task automatic wait_idle();
    int budget = 500;
    while (o_state != 3'd0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got state %0d expected 0", o_state);
    end
  endtask

  initial begin
    int budget;
    #1 rstn = 1'b0;
    #1;
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_cycle", o_cycle, 64'd0);
    check("rst_instret", o_instret, 64'd0);
    check("rst_cause", 64'(o_trap_cause), 64'd0);
    check("rst_strobes", 64'({o_fetch_valid, o_instr_ready, o_exec_valid,
          o_mem_valid, o_rsp_ready, o_wb_en, o_pc_en, o_trap}), 64'd0);
    #10 rstn = 1'b1;

    repeat (3) @(negedge clk);
    check("idle_state", 64'(o_state), 64'd0);
    check("idle_cycle", o_cycle, 64'd0);
    i_run = 1'b1;
    wait_done(200);

    budget = 500;
    while (!o_exec_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reach_execute", 64'(o_exec_valid), 64'd1);
    i_run = 1'b0;
    wait_idle();
    repeat (4) begin
      @(negedge clk);
      check("stop_state", 64'(o_state), 64'd0);
      check("stop_cycle", o_cycle, mdl_cycle);
      check("stop_instret", o_instret, mdl_instret);
    end
    check("stop_drain", 64'(q.size()), 64'd0);

    i_run = 1'b1;
    wait_done(n_done + 100);

    hold_rsp = 1'b1;
    budget = 2000;
    while (budget > 0) begin
      @(negedge clk);
      if (o_rsp_ready) break;
      budget--;
    end
    check("reach_mem_wait", 64'(o_rsp_ready), 64'd1);
    #1 rstn = 1'b0;
    #1;
    check("arst_state", 64'(o_state), 64'd0);
    check("arst_cycle", o_cycle, 64'd0);
    check("arst_instret", o_instret, 64'd0);
    check("arst_rsp_ready", 64'(o_rsp_ready), 64'd0);
    @(negedge clk);
    hold_rsp = 1'b0;
    #2 rstn = 1'b1;
    wait_done(n_done + 60);

    i_run = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("end_drain", 64'(q.size()), 64'd0);
    check("end_cycle", o_cycle, mdl_cycle);
    check("end_instret", o_instret, mdl_instret);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d errors %0d",
             checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
